// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and feature types, used by conv and max_pool.
package cnn_pkg;

    localparam int NUM_FMAPS = 6;
    localparam int DW        = 8;
    localparam int IN_W      = 28;
    localparam int IN_H      = 28;

    typedef logic signed [DW-1:0] feature_t;
    typedef feature_t fmap_vec_t [0:NUM_FMAPS-1];

endpackage

// File: rtl/pool_lane.sv
// One feature-map lane of the 2x2 max pool: left-pixel register, half-row line buffer
// and the signed max tree that forms the window result.
module pool_lane #(
    parameter int DW    = 8,
    parameter int PAIRS = 14,
    parameter int PW    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_acc,
    input  logic                 i_col_odd,
    input  logic                 i_row_odd,
    input  logic [PW-1:0]        i_pair,
    input  logic signed [DW-1:0] i_pixel,
    output logic signed [DW-1:0] o_window_max
);

    logic signed [DW-1:0] h_q;
    logic signed [DW-1:0] lb_q [PAIRS];
    logic signed [DW-1:0] pair_max;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign pair_max     = smax(h_q, i_pixel);
    assign o_window_max = smax(lb_q[i_pair], pair_max);

    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q <= '0;
        end else if (i_acc && !i_col_odd) begin
            h_q <= i_pixel;
        end
    end

    // NOTE: no reset on the line buffer; each entry is written on an even row before the odd row reads it.
    always_ff @(posedge i_clk) begin
        if (i_acc && i_col_odd && !i_row_odd) begin
            lb_q[i_pair] <= pair_max;
        end
    end

endmodule

// File: rtl/max_pool.sv
// Streaming 2x2 stride-2 max pool: raster counters, valid/ready handshake and the
// registered pooled output; per-map window logic lives in pool_lane.
module max_pool #(
    parameter int IN_W      = cnn_pkg::IN_W,
    parameter int IN_H      = cnn_pkg::IN_H,
    parameter int NUM_FMAPS = cnn_pkg::NUM_FMAPS,
    parameter int DW        = cnn_pkg::DW
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_feature_valid,
    input  logic signed [DW-1:0] i_features [NUM_FMAPS],
    output logic                 o_ready_feature,
    output logic                 o_feature_valid,
    output logic signed [DW-1:0] o_features [NUM_FMAPS],
    input  logic                 i_ready_feature
);

    localparam int CW    = $clog2(IN_W);
    localparam int RW    = (IN_H > 2) ? $clog2(IN_H) : 1;
    localparam int PAIRS = IN_W / 2;
    localparam int PW    = CW - 1;

    if ((IN_W % 2) != 0 || IN_W < 4) begin : g_bad_width
        $error("max_pool: IN_W must be even and at least 4");
    end
    if ((IN_H % 2) != 0 || IN_H < 2) begin : g_bad_height
        $error("max_pool: IN_H must be even and at least 2");
    end

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic                 valid_q, valid_d;
    logic signed [DW-1:0] feat_q  [NUM_FMAPS];
    logic signed [DW-1:0] win_max [NUM_FMAPS];
    logic                 acc;
    logic                 emit;

    assign o_ready_feature = !valid_q || i_ready_feature;
    assign acc             = i_feature_valid && o_ready_feature;
    // The bottom-right pixel of a window sits at odd column and odd row.
    assign emit            = acc && col_q[0] && row_q[0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        valid_d = emit || (valid_q && !i_ready_feature);
        if (acc) begin
            if (col_q == CW'(IN_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IN_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < NUM_FMAPS; k++) begin
                feat_q[k] <= '0;
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            if (emit) begin
                for (int k = 0; k < NUM_FMAPS; k++) begin
                    feat_q[k] <= win_max[k];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_FMAPS; k++) begin : g_lane
        pool_lane #(
            .DW    (DW),
            .PAIRS (PAIRS),
            .PW    (PW)
        ) u_lane (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_acc        (acc),
            .i_col_odd    (col_q[0]),
            .i_row_odd    (row_q[0]),
            .i_pair       (col_q[CW-1:1]),
            .i_pixel      (i_features[k]),
            .o_window_max (win_max[k])
        );
    end

    assign o_feature_valid = valid_q;
    assign o_features      = feat_q;

endmodule

// File: tb/tb_max_pool.sv
// Scoreboard bench for max_pool: expected pooled beats are queued as pixels are driven
// and popped by a monitor whenever the DUT retires a beat.
module tb_max_pool;
    import cnn_pkg::*;

    localparam int OW    = IN_W / 2;
    localparam int OH    = IN_H / 2;
    localparam int BEATS = OW * OH;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_feature_valid;
    logic                 i_ready_feature;
    logic                 o_ready_feature;
    logic                 o_feature_valid;
    logic signed [DW-1:0] i_features [NUM_FMAPS];
    logic signed [DW-1:0] o_features [NUM_FMAPS];

    int total = 0;
    int bad   = 0;
    int beats = 0;
    int cur_r = -1;
    int cur_c = -1;
    logic [NUM_FMAPS*DW-1:0] exp_q [$];

    always #5 i_clk = ~i_clk;

    max_pool dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_feature_valid (i_feature_valid),
        .i_features      (i_features),
        .o_ready_feature (o_ready_feature),
        .o_feature_valid (o_feature_valid),
        .o_features      (o_features),
        .i_ready_feature (i_ready_feature)
    );

    // Pixel generators: mode 0 is a ramp r+c-k+off, mode 1 the signed-compare pattern.
    function automatic logic signed [DW-1:0] pix_val(input int mode, input int r, input int c,
                                                     input int k, input int off);
        int rr = r / 2;
        int cc = c / 2;
        int p  = (r % 2) * 2 + (c % 2);
        int hot;
        if (mode == 0) return DW'(r + c - k + off);
        if (rr == 0 && cc == 0) begin
            case (p)
                0:       return DW'(127);
                1:       return DW'(-128);
                2:       return DW'(0);
                default: return DW'(5);
            endcase
        end
        hot = (rr * OW + cc + k) % 4;
        return (p == hot) ? DW'(-1) : DW'(-128);
    endfunction

    function automatic logic signed [DW-1:0] exp_val(input int mode, input int rr, input int cc,
                                                     input int k, input int off);
        if (mode == 0) return DW'(2 * rr + 2 * cc + 2 - k + off);
        return (rr == 0 && cc == 0) ? DW'(127) : DW'(-1);
    endfunction

    function automatic logic [NUM_FMAPS*DW-1:0] pack_out();
        logic [NUM_FMAPS*DW-1:0] v;
        for (int k = 0; k < NUM_FMAPS; k++) v[k*DW +: DW] = o_features[k];
        return v;
    endfunction

    // Monitor: a beat retires on the next rising edge when valid and ready are both high here.
    always @(negedge i_clk) begin
        logic [NUM_FMAPS*DW-1:0] got, exp;
        if (!i_rst && o_feature_valid && i_ready_feature) begin
            beats++;
            total++;
            got = pack_out();
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: got %h, required no beat", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL beat_value #%0d: got %h, required %h", beats, got, exp);
                end
            end
        end
    end

    task automatic drive_pixel(input int mode, input int r, input int c, input int off,
                               input bit gaps);
        bit ok;
        int budget = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 0) begin
                i_feature_valid = 1'b0;
                for (int k = 0; k < NUM_FMAPS; k++) i_features[k] = DW'($urandom);
                @(posedge i_clk); #1;
            end
        end
        cur_r = r;
        cur_c = c;
        for (int k = 0; k < NUM_FMAPS; k++) i_features[k] = pix_val(mode, r, c, k, off);
        i_feature_valid = 1'b1;
        forever begin
            @(negedge i_clk);
            ok = o_ready_feature;
            @(posedge i_clk); #1;
            if (ok) break;
            budget++;
            if (budget > 200) begin
                $display("FAIL accept_timeout at (%0d,%0d): got no accept, required accept", r, c);
                $fatal(1, "input stalled");
            end
        end
    endtask

    task automatic send_frame(input int mode, input int off, input bit gaps,
                              input int last_r, input int last_c);
        logic [NUM_FMAPS*DW-1:0] e;
        for (int r = 0; r < IN_H; r++) begin
            for (int c = 0; c < IN_W; c++) begin
                if (r > last_r || (r == last_r && c > last_c)) break;
                if ((r % 2) == 1 && (c % 2) == 1) begin
                    for (int k = 0; k < NUM_FMAPS; k++) e[k*DW +: DW] = exp_val(mode, r / 2, c / 2, k, off);
                    exp_q.push_back(e);
                end
                drive_pixel(mode, r, c, off, gaps);
            end
        end
        i_feature_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int b0, input int nbeats);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge i_clk);
        @(posedge i_clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
        end
        total++;
        if (beats - b0 != nbeats) begin
            bad++;
            $display("FAIL %s_beat_count: got %0d, required %0d", name, beats - b0, nbeats);
        end
    endtask

    task automatic test_reset();
        bit zero = 1'b1;
        i_rst = 1'b1;
        i_feature_valid = 1'b0;
        i_ready_feature = 1'b1;
        for (int k = 0; k < NUM_FMAPS; k++) i_features[k] = '0;
        repeat (3) @(posedge i_clk);
        #1;
        for (int k = 0; k < NUM_FMAPS; k++) if (o_features[k] !== '0) zero = 1'b0;
        total++;
        if (o_feature_valid !== 1'b0 || o_ready_feature !== 1'b1 || !zero) begin
            bad++;
            $display("FAIL reset_state: got valid=%b ready=%b zero=%b, required 0 1 1",
                     o_feature_valid, o_ready_feature, zero);
        end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_ramp();
        int b0 = beats;
        send_frame(0, 0, 1'b0, IN_H - 1, IN_W - 1);
        wait_drain("ramp", b0, BEATS);
    endtask

    task automatic test_signed();
        int b0 = beats;
        send_frame(1, 0, 1'b0, IN_H - 1, IN_W - 1);
        wait_drain("signed", b0, BEATS);
    endtask

    task automatic stall_proc();
        logic signed [DW-1:0] cap [NUM_FMAPS];
        bit found = 1'b0;
        bit same;
        for (int i = 0; i < 5000; i++) begin
            if (cur_r == 5 && cur_c == 9) begin found = 1'b1; break; end
            @(posedge i_clk); #1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL stall_trigger: got no (5,9) pixel, required one");
            return;
        end
        i_ready_feature = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            if (o_feature_valid) begin found = 1'b1; break; end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL stall_valid: got valid=0, required 1 during stall");
        end
        cap = o_features;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            same = 1'b1;
            for (int k = 0; k < NUM_FMAPS; k++) if (o_features[k] !== cap[k]) same = 1'b0;
            total++;
            if (o_ready_feature !== 1'b0 || o_feature_valid !== 1'b1 || !same) begin
                bad++;
                $display("FAIL stall_hold cycle %0d: got ready=%b valid=%b stable=%b, required 0 1 1",
                         i, o_ready_feature, o_feature_valid, same);
            end
        end
        @(posedge i_clk); #1;
        i_ready_feature = 1'b1;
    endtask

    task automatic test_backpressure();
        int b0 = beats;
        cur_r = -1;
        cur_c = -1;
        fork
            send_frame(0, 0, 1'b0, IN_H - 1, IN_W - 1);
            stall_proc();
        join
        wait_drain("backpressure", b0, BEATS);
    endtask

    task automatic test_gapped();
        int b0 = beats;
        send_frame(0, 0, 1'b1, IN_H - 1, IN_W - 1);
        wait_drain("gapped", b0, BEATS);
    endtask

    task automatic test_mid_reset();
        bit zero = 1'b1;
        int b0;
        send_frame(0, 0, 1'b0, 9, 5);
        i_ready_feature = 1'b0;
        @(negedge i_clk);
        total++;
        if (o_feature_valid !== 1'b1) begin
            bad++;
            $display("FAIL pending_before_reset: got valid=%b, required 1", o_feature_valid);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        i_feature_valid = 1'b1;
        for (int k = 0; k < NUM_FMAPS; k++) i_features[k] = DW'($urandom);
        @(posedge i_clk); #1;
        for (int k = 0; k < NUM_FMAPS; k++) if (o_features[k] !== '0) zero = 1'b0;
        total++;
        if (o_feature_valid !== 1'b0 || o_ready_feature !== 1'b1 || !zero) begin
            bad++;
            $display("FAIL mid_reset_state: got valid=%b ready=%b zero=%b, required 0 1 1",
                     o_feature_valid, o_ready_feature, zero);
        end
        i_rst = 1'b0;
        i_feature_valid = 1'b0;
        i_ready_feature = 1'b1;
        void'(exp_q.pop_back());
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pre_reset_beats: got %0d outstanding, required 0", exp_q.size());
        end
        @(posedge i_clk); #1;
        b0 = beats;
        send_frame(0, 0, 1'b0, IN_H - 1, IN_W - 1);
        wait_drain("after_reset", b0, BEATS);
    endtask

    task automatic test_back_to_back();
        int b0 = beats;
        send_frame(0, 0, 1'b0, IN_H - 1, IN_W - 1);
        send_frame(0, 3, 1'b0, IN_H - 1, IN_W - 1);
        wait_drain("back_to_back", b0, 2 * BEATS);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_signed();
        test_backpressure();
        test_gapped();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
